// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, states, ALU controls,
// mux selects, and the per-state control word.
package mc_control_fsm_pkg;

  localparam int ALUCTRL_W = 3;
  localparam int STATE_W   = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [ALUCTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10} res_src_t;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} src_a_t;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} src_b_t;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;

  // pc_write here is the unconditional part; the BEQ branch term is added by the top.
  typedef struct packed {
    logic     pc_write;
    logic     adr_src;
    logic     mem_write;
    logic     ir_write;
    res_src_t result_src;
    src_a_t   alu_src_a;
    src_b_t   alu_src_b;
    logic     reg_write;
    aluop_t   aluop;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1;  c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;  c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;   c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;  c.reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src = 1'b1;         c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;   c.alu_src_b = SRCB_RS2;  c.aluop = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;   c.alu_src_b = SRCB_IMM;  c.aluop = ALUOP_FUNCT;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = SRCA_RS1;   c.alu_src_b = SRCB_RS2;  c.aluop = ALUOP_SUB;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.pc_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic imm_src_t imm_sel(logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/datapath bundle: the controller is the master (drives controls, reads the
// latched instruction fields and the ALU zero flag).
interface mc_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [mc_control_fsm_pkg::ALUCTRL_W-1:0] alucontrol;
  logic       illegal;
  logic [mc_control_fsm_pkg::STATE_W-1:0]   state_o;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alucontrol, illegal, state_o
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alucontrol, illegal, state_o
  );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational ALU decoder shared with the single-cycle core.
// MC_CTRL_SLT_EN: when defined, funct3 010 decodes to slt instead of being illegal.
module mc_control_fsm_alu_decoder
  import mc_control_fsm_pkg::*;
(
  input  aluop_t    i_aluop,
  input  logic [2:0] i_funct3,
  input  logic      i_op5,
  input  logic      i_funct7b5,
  output alu_ctrl_t o_alucontrol,
  output logic      o_funct_illegal
);

  alu_ctrl_t w_funct;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case statements can leave a value held (which would infer a latch).
  always_comb begin
    w_funct         = ALU_ADD;
    o_funct_illegal = 1'b0;
    case (i_funct3)
      3'b000:  w_funct = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b110:  w_funct = ALU_OR;
      3'b111:  w_funct = ALU_AND;
`ifdef MC_CTRL_SLT_EN
      3'b010:  w_funct = ALU_SLT;
`else
      3'b010:  o_funct_illegal = 1'b1;
`endif
      default: o_funct_illegal = 1'b1;
    endcase

    case (i_aluop)
      ALUOP_SUB:   o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: o_alucontrol = w_funct;
      default:     o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM (FETCH/DECODE/EXECUTE/MEM/WB) driving the ALU and datapath.
// MC_CTRL_SLT_EN enables slt/slti decode in the ALU decoder.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  mc_control_fsm_if.master bus
);

  state_t    r_state;
  state_t    w_next;
  ctrl_t     r_ctrl;
  logic      w_decode_bad;
  logic      w_funct_illegal;
  alu_ctrl_t w_alucontrol;

  mc_control_fsm_alu_decoder u_alu_dec (
    .i_aluop        (r_ctrl.aluop),
    .i_funct3       (bus.funct3),
    .i_op5          (bus.op[5]),
    .i_funct7b5     (bus.funct7b5),
    .o_alucontrol   (w_alucontrol),
    .o_funct_illegal(w_funct_illegal)
  );

  always_comb begin
    w_next       = S_FETCH;
    w_decode_bad = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:   if (w_funct_illegal) w_decode_bad = 1'b1; else w_next = S_EXECR;
          OP_I:   if (w_funct_illegal) w_decode_bad = 1'b1; else w_next = S_EXECI;
          OP_BEQ: if (bus.funct3 != 3'b000) w_decode_bad = 1'b1; else w_next = S_BEQ;
          OP_JAL: w_next = S_JAL;
          default: w_decode_bad = 1'b1;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      w_next = S_MEMREAD;
        else if (bus.op == OP_SW) w_next = S_MEMWRITE;
      end
      S_MEMREAD:                 w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:   w_next = S_ALUWB;
      default:                   w_next = S_FETCH;
    endcase
  end

  // The control word is registered from the next state so it is aligned with r_state;
  // its reset value is the FETCH word so the first fetch is ready at deassertion.
  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ctrl  <= state_ctrl(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
    end
  end

  // Write enables are qualified by rst_n so nothing writes while reset is held.
  assign bus.pc_write   = rst_n & (r_ctrl.pc_write | ((r_state == S_BEQ) & bus.zero));
  assign bus.ir_write   = rst_n & r_ctrl.ir_write;
  assign bus.mem_write  = rst_n & r_ctrl.mem_write;
  assign bus.reg_write  = rst_n & r_ctrl.reg_write;
  assign bus.illegal    = rst_n & (r_state == S_DECODE) & w_decode_bad;
  assign bus.adr_src    = r_ctrl.adr_src;
  assign bus.result_src = r_ctrl.result_src;
  assign bus.alu_src_a  = r_ctrl.alu_src_a;
  assign bus.alu_src_b  = r_ctrl.alu_src_b;
  assign bus.imm_src    = imm_sel(bus.op);
  assign bus.alucontrol = w_alucontrol;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: expected per-cycle outputs are queued when an
// instruction is driven and popped/compared each cycle.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic       reg_write;
    logic [2:0] alucontrol;
    logic       illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_funct(logic [2:0] f3, logic op5, logic f7, output logic bad);
    bad = 1'b0;
    case (f3)
      3'b000: return (op5 && f7) ? 4'd1 : 4'd0;
      3'b110: return 4'd3;
      3'b111: return 4'd2;
`ifdef MC_CTRL_SLT_EN
      3'b010: return 4'd5;
`endif
      default: begin bad = 1'b1; return 4'd0; end
    endcase
  endfunction

  function automatic exp_t model(int st, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                                 bit in_rst);
    exp_t e;
    logic fbad;
    logic [3:0] fc;
    e = '0;
    e.state = st[3:0];
    fc = ref_funct(f3, op[5], f7, fbad);
    e.imm_src = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    case (st)
      0:  begin e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      1:  begin
            e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
            if (op == OP_R || op == OP_I) e.illegal = fbad;
            else if (op == OP_BEQ)        e.illegal = (f3 != 3'b000);
            else                          e.illegal = !(op == OP_LW || op == OP_SW || op == OP_JAL);
          end
      2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      3:  e.adr_src = 1;
      4:  begin e.result_src = 2'b01; e.reg_write = 1; end
      5:  begin e.adr_src = 1; e.mem_write = 1; end
      6:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b00; e.alucontrol = fc[2:0]; end
      7:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alucontrol = fc[2:0]; end
      8:  e.reg_write = 1;
      9:  begin e.alu_src_a = 2'b10; e.alucontrol = 3'b001; e.pc_write = z; end
      10: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; end
      default: ;
    endcase
    if (in_rst) begin
      e.pc_write = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0; e.illegal = 0;
    end
    return e;
  endfunction

  task automatic compare_cycle(input exp_t e);
    string p;
    p = $sformatf("st%0d.", e.state);
    check_eq({p, "state"},      32'(bus.state_o),    32'(e.state));
    check_eq({p, "pc_write"},   32'(bus.pc_write),   32'(e.pc_write));
    check_eq({p, "adr_src"},    32'(bus.adr_src),    32'(e.adr_src));
    check_eq({p, "mem_write"},  32'(bus.mem_write),  32'(e.mem_write));
    check_eq({p, "ir_write"},   32'(bus.ir_write),   32'(e.ir_write));
    check_eq({p, "result_src"}, 32'(bus.result_src), 32'(e.result_src));
    check_eq({p, "alu_src_a"},  32'(bus.alu_src_a),  32'(e.alu_src_a));
    check_eq({p, "alu_src_b"},  32'(bus.alu_src_b),  32'(e.alu_src_b));
    check_eq({p, "imm_src"},    32'(bus.imm_src),    32'(e.imm_src));
    check_eq({p, "reg_write"},  32'(bus.reg_write),  32'(e.reg_write));
    check_eq({p, "alucontrol"}, 32'(bus.alucontrol), 32'(e.alucontrol));
    check_eq({p, "illegal"},    32'(bus.illegal),    32'(e.illegal));
  endtask

  // Expected state path is packed low nibble first. Called at a negedge with the DUT
  // in FETCH; returns at the negedge after the last listed state. With rst_last set,
  // reset is asserted in place of the last state and the reset values are expected.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input logic [31:0] seq, input int n,
                           input bit rst_last = 1'b0);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    for (int i = 0; i < n; i++) begin
      if (rst_last && i == n - 1) sb.push_back(model(0, op, f3, f7, z, 1'b1));
      else                        sb.push_back(model(int'(seq[4*i +: 4]), op, f3, f7, z, 1'b0));
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (rst_last && i == n - 1) rst_n = 1'b0;
      #1;
      compare_cycle(sb.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    bus.op = OP_R; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sb.push_back(model(0, OP_R, 3'b000, 1'b0, 1'b0, 1'b1));
      #1;
      compare_cycle(sb.pop_front());
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(OP_R,   3'b000, 1'b0, 1'b0, 32'h8610, 4);   // add
    run_instr(OP_R,   3'b000, 1'b1, 1'b0, 32'h8610, 4);   // sub
    run_instr(OP_R,   3'b110, 1'b0, 1'b0, 32'h8610, 4);   // or
    run_instr(OP_R,   3'b111, 1'b1, 1'b0, 32'h8610, 4);   // and
    run_instr(OP_I,   3'b000, 1'b1, 1'b0, 32'h8710, 4);   // addi stays add with bit30 set
    run_instr(OP_I,   3'b110, 1'b0, 1'b0, 32'h8710, 4);   // ori
    run_instr(OP_LW,  3'b010, 1'b0, 1'b0, 32'h43210, 5);
    run_instr(OP_SW,  3'b010, 1'b0, 1'b0, 32'h5210, 4);
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 32'h910, 3);
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 32'h910, 3);
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 32'h8A10, 4);
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 32'h10, 2);
    run_instr(OP_BEQ, 3'b001, 1'b0, 1'b1, 32'h10, 2);
    run_instr(OP_R,   3'b001, 1'b0, 1'b0, 32'h10, 2);
    run_instr(OP_I,   3'b100, 1'b0, 1'b0, 32'h10, 2);
`ifdef MC_CTRL_SLT_EN
    run_instr(OP_R,   3'b010, 1'b0, 1'b0, 32'h8610, 4);
`else
    run_instr(OP_R,   3'b010, 1'b0, 1'b0, 32'h10, 2);
`endif
    run_instr(OP_SW,  3'b010, 1'b0, 1'b0, 32'h5210, 4, 1'b1);   // reset lands in MEMWRITE
    rst_n = 1'b1;
    run_instr(OP_R,   3'b000, 1'b1, 1'b0, 32'h8610, 4);
    run_instr(OP_LW,  3'b010, 1'b0, 1'b0, 32'h43210, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
